// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS core. It sequences the shared datapath
// through FETCH/DECODE/EXEC/S4/S5 and counts the instructions it retires.
module mips_multicycle_ctrl #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    output logic                   pc_write,
    output logic                   iord,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic [1:0]             alu_src_a,
    output logic [2:0]             alu_src_b,
    output logic [3:0]             alu_ctrl,
    output logic                   pc_src,
    output logic [3:0]             count_state,
    output logic                   instr_done,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_OR, OP_SLL, OP_ADDI, OP_ANDI, OP_LUI,
        OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_BAD
    } op_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    state_t                 state_q, state_d;
    logic                   zero_q, zero_d;
    logic [COUNT_WIDTH-1:0] instr_count_q, instr_count_d;
    op_t                    op;

    always_comb begin
        op = OP_BAD;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   op = OP_ADD;
                    6'h25:   op = OP_OR;
                    6'h00:   op = OP_SLL;
                    default: op = OP_BAD;
                endcase
            end
            6'h08:   op = OP_ADDI;
            6'h0C:   op = OP_ANDI;
            6'h0F:   op = OP_LUI;
            6'h04:   op = OP_BEQ;
            6'h05:   op = OP_BNE;
            6'h23:   op = OP_LW;
            6'h2B:   op = OP_SW;
            default: op = OP_BAD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        zero_d     = zero_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 3'b000;
        alu_ctrl   = ALU_AND;
        pc_src     = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = 3'b001;
                alu_ctrl  = ALU_ADD;
                pc_write  = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively here and parked in ALUOut.
                alu_src_b = 3'b101;
                alu_ctrl  = ALU_ADD;
                if (op == OP_BAD) begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = S4;
                case (op)
                    OP_ADD:  begin alu_src_a = 2'b01; alu_src_b = 3'b000; alu_ctrl = ALU_ADD; end
                    OP_OR:   begin alu_src_a = 2'b01; alu_src_b = 3'b000; alu_ctrl = ALU_OR;  end
                    OP_SLL:  begin alu_src_a = 2'b10; alu_src_b = 3'b000; alu_ctrl = ALU_SLL; end
                    OP_ADDI: begin alu_src_a = 2'b01; alu_src_b = 3'b010; alu_ctrl = ALU_ADD; end
                    OP_ANDI: begin alu_src_a = 2'b01; alu_src_b = 3'b011; alu_ctrl = ALU_AND; end
                    OP_LUI:  begin alu_src_a = 2'b11; alu_src_b = 3'b100; alu_ctrl = ALU_ADD; end
                    OP_LW, OP_SW: begin
                        alu_src_a = 2'b01; alu_src_b = 3'b010; alu_ctrl = ALU_ADD;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src_a = 2'b01; alu_src_b = 3'b000; alu_ctrl = ALU_SUB;
                        zero_d    = zero;
                    end
                    default: ;
                endcase
            end
            S4: begin
                state_d = FETCH;
                case (op)
                    OP_ADD, OP_OR, OP_SLL: begin
                        reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_LUI: begin
                        reg_write = 1'b1; instr_done = 1'b1;
                    end
                    OP_BEQ: begin pc_src = 1'b1; pc_write = zero_q;  instr_done = 1'b1; end
                    OP_BNE: begin pc_src = 1'b1; pc_write = ~zero_q; instr_done = 1'b1; end
                    OP_LW:  begin iord = 1'b1; state_d = S5; end
                    OP_SW:  begin iord = 1'b1; mem_write = 1'b1; state_d = S5; end
                    default: ;
                endcase
            end
            S5: begin
                state_d = FETCH;
                case (op)
                    OP_LW: begin mem_to_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
                    OP_SW: instr_done = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = FETCH;
        endcase

        instr_count_d = instr_count_q;
        if (instr_done) begin
            instr_count_d = instr_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            zero_q        <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            zero_q        <= zero_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign count_state = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core (MIPS_new).
- Sequences the shared datapath across states: register file, ALU, unified instruction/data memory, PC, IR, A/B/ALUOut/MDR registers.
- Decodes opcode/funct from the IR and drives every mux select and write strobe per cycle.
- Exports the current state as count_state for bench alignment, plus a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, combinational
- pc_write  output  1  PC load strobe
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load strobe
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write strobe
- alu_src_a  output  2  SrcA select: 00 = PC, 01 = A, 10 = shamt zero-extended, 11 = 0
- alu_src_b  output  3  SrcB select: 000 = B, 001 = 4, 010 = sign-extended imm, 011 = zero-extended imm, 100 = imm<<16, 101 = sign-extended imm<<2
- alu_ctrl  output  4  ALU op: 0010 = ADD, 0110 = SUB, 0000 = AND, 0001 = OR, 1000 = SLL (SrcB<<SrcA[4:0])
- pc_src  output  1  PC source: 0 = ALU result, 1 = ALUOut
- count_state  output  4  current state code
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE when the opcode is unsupported
- instr_count  output  COUNT_WIDTH  retired-instruction count

Behaviour:
State codes:
- IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, S4 = 4, S5 = 5.
- Codes 6–15 are unused. If the state register ever holds one, the next state is FETCH.

Reset:
- reset high at a clk edge: state ← IDLE, instr_count ← 0, zero_q ← 0.
- reset has priority over every transition, including mid-instruction. No strobe may be asserted in the cycle after reset is sampled.
- IDLE → FETCH unconditionally on the next edge after reset is low.

Output timing:
- All strobes and selects are combinational from the state register, opcode and funct.
- Unlisted outputs are 0 in every state. IDLE drives all zeros.

Per-state outputs and transitions:
- FETCH: iord=0, ir_write=1, alu_src_a=00, alu_src_b=001, ADD, pc_src=0, pc_write=1. Next state DECODE.
- DECODE: alu_src_a=00, alu_src_b=101, ADD (branch target goes to ALUOut).
  - Supported opcodes: 0x00 with funct 0x20 add, 0x25 or, 0x00 sll; 0x08 addi; 0x0C andi; 0x0F lui; 0x04 beq; 0x05 bne; 0x23 lw; 0x2B sw.
  - Supported → EXEC.
  - Unsupported (including R-type with any other funct) → illegal_op=1, next state FETCH. No count increment.
- EXEC:
  - add/or: src_a=01, src_b=000, ADD/OR.
  - sll: src_a=10, src_b=000, SLL.
  - addi: 01/010/ADD.
  - andi: 01/011/AND.
  - lui: 11/100/ADD.
  - lw/sw: 01/010/ADD (effective address).
  - beq/bne: 01/000/SUB; zero_q ← zero at end of cycle.
  - Next state S4 for all.
- S4:
  - R-type: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
  - addi/andi/lui: reg_dst=0, reg_write=1, instr_done=1 → FETCH.
  - beq: pc_src=1, pc_write=zero_q, instr_done=1 → FETCH.
  - bne: pc_src=1, pc_write=!zero_q, instr_done=1 → FETCH.
  - lw: iord=1 (MDR captures read data) → S5.
  - sw: iord=1, mem_write=1 → S5.
- S5:
  - lw: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1.
  - sw: dummy cycle, instr_done=1.
  - Next state FETCH.

Cycle counts:
- ALU and branch instructions: 4 cycles (1-2-3-4).
- lw/sw: 5 cycles (1-2-3-4-5).

Retired-instruction counter:
- instr_count increments on every edge where instr_done=1.
- Wraps from 2^COUNT_WIDTH-1 to 0.

Test Plan:
- Reset held 2 cycles then released → count_state 0 then 1,2,3,4; all strobes 0 during reset; pc_write=1, ir_write=1 in FETCH.
- addi $t0,$t0,3 (opcode 0x08) → EXEC src_a=01, src_b=010, alu_ctrl=0010; S4 reg_write=1, reg_dst=0; instr_count 0→1.
- R-type sll (funct 0x00) then add (funct 0x20) → EXEC src_a=10/alu_ctrl=1000, then src_a=01/alu_ctrl=0010; S4 reg_dst=1 for both.
- beq with zero=1 in EXEC → S4 pc_write=1, pc_src=1; same stimulus with bne → pc_write=0; zero=0 with bne → pc_write=1.
- sw then lw (0x2B, 0x23) → sw: S4 mem_write=1, iord=1, S5 no strobes; lw: S4 iord=1, S5 reg_write=1, mem_to_reg=1; 5-cycle state sequence each.
- opcode 0x3F in DECODE → illegal_op=1 for one cycle, next state FETCH, instr_count unchanged; reset asserted during S4 of a sw → mem_write 0 next cycle, state 0.
